carry_chain_counter: RTL



---
 rtl/carry_chain_pkg.sv | 13 +
 rtl/cc_bit.sv | 38 +++
 rtl/carry_chain_counter.sv | 68 ++++++
 3 files changed

// File: rtl/carry_chain_pkg.sv
// rtl/carry_chain_pkg.sv - shared direction encodings and width limit for carry_chain_counter
package carry_chain_pkg;

  localparam logic CC_DIR_UP    = 1'b1;
  localparam logic CC_DIR_DOWN  = 1'b0;
  localparam int   CC_MIN_WIDTH = 2;

  // Up overflows on a carry out of the top stage; down underflows when no carry emerges.
  function automatic logic cc_overflow(input logic dir, input logic chain_cout);
    return (dir == CC_DIR_UP) ? chain_cout : ~chain_cout;
  endfunction

endpackage

// File: rtl/cc_bit.sv
// rtl/cc_bit.sv - one propagate/generate carry stage with load mux and reset-to-0 flip-flop
module cc_bit
  import carry_chain_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dir,
  input  logic cin,
  input  logic load,
  input  logic load_val,
  input  logic adv,
  output logic q,
  output logic cout,
  output logic nxt
);

  logic p;
  logic g;
  logic sum;

  // Down-counting adds all-ones: propagate on ~q, generate on q.
  always_comb begin
    p    = (dir == CC_DIR_DOWN) ? ~q : q;
    g    = (dir == CC_DIR_DOWN) ? q : 1'b0;
    sum  = p ^ cin;
    cout = p ? cin : g;
    nxt  = load ? load_val : (adv ? sum : q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/carry_chain_counter.sv
// rtl/carry_chain_counter.sv - loadable up/down ripple-carry counter with wrap and match flags
// Optional saturation at the limits when CARRY_CHAIN_COUNTER_SATURATE_EN is defined.
module carry_chain_counter
  import carry_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             L,
  input  logic             U,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             MATCH
);

  generate
    if (WIDTH < CC_MIN_WIDTH) begin : g_width_check
      $error("carry_chain_counter: WIDTH must be at least %0d", CC_MIN_WIDTH);
    end
  endgenerate

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] nxt;
  logic             overflow;
  logic             adv;

  assign carry[0] = (U == CC_DIR_UP);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cc_bit u_bit (
      .clk      (C),
      .rst_n    (R),
      .dir      (U),
      .cin      (carry[i]),
      .load     (L),
      .load_val (D[i]),
      .adv      (adv),
      .q        (Q[i]),
      .cout     (carry[i+1]),
      .nxt      (nxt[i])
    );
  end

  assign overflow = cc_overflow(U, carry[WIDTH]);

`ifdef CARRY_CHAIN_COUNTER_SATURATE_EN
  // At a limit the count is blocked, so Q holds at all-ones or zero.
  assign adv = E & ~overflow;
`else
  assign adv = E;
`endif

  // CO flags an overflow event in either mode; MATCH compares the value being written.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      CO    <= 1'b0;
      MATCH <= 1'b0;
    end else begin
      CO    <= ~L & E & overflow;
      MATCH <= (nxt == M);
    end
  end

endmodule
